// File: rtl/karatsuba_pkg.sv
// Shared definitions for the sequential 64x64 Karatsuba multiplier:
// FSM states, core width and the shift applied to each partial product.
package karatsuba_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CORE_W = 32;
   localparam int NUM_PP = 4;

   localparam logic [6:0] PP_SHIFT0 = 7'd0;
   localparam logic [6:0] PP_SHIFT1 = 7'd32;
   localparam logic [6:0] PP_SHIFT2 = 7'd32;
   localparam logic [6:0] PP_SHIFT3 = 7'd64;

   localparam logic [1:0] LAST_IDX = 2'(NUM_PP - 1);

   function automatic logic [6:0] pp_shift(input logic [1:0] idx);
      logic [6:0] sh;
      case (idx)
         2'd0:    sh = PP_SHIFT0;
         2'd1:    sh = PP_SHIFT1;
         2'd2:    sh = PP_SHIFT2;
         default: sh = PP_SHIFT3;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/karatsuba_mul_32.sv
// Combinational 32x32 unsigned multiplier using one level of Karatsuba
// decomposition on 16-bit halves (three 16/17-bit products).
module karatsuba_mul_32 (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_p
);

   logic [31:0] w_z0;
   logic [31:0] w_z2;
   logic [16:0] w_sa;
   logic [16:0] w_sb;
   logic [33:0] w_zm;
   logic [33:0] w_z1;

   assign w_z0 = i_a[15:0] * i_b[15:0];
   assign w_z2 = i_a[31:16] * i_b[31:16];
   assign w_sa = {1'b0, i_a[15:0]} + {1'b0, i_a[31:16]};
   assign w_sb = {1'b0, i_b[15:0]} + {1'b0, i_b[31:16]};
   assign w_zm = w_sa * w_sb;
   // Middle term a0*b1 + a1*b0 is always non-negative and below 2^33.
   assign w_z1 = w_zm - {2'b00, w_z0} - {2'b00, w_z2};

   assign o_p = {w_z2, w_z0} + {14'd0, w_z1, 16'd0};

endmodule

// File: rtl/karatsuba_mul_64_seq.sv
// Iterative 64x64 unsigned multiplier feeding four half-word pairs through a
// shared 32-bit Karatsuba core. Define KARATSUBA_MUL_64_SEQ_PIPE_EN to register
// the core output ahead of the 128-bit accumulator (one extra drain cycle).
module karatsuba_mul_64_seq
   import karatsuba_pkg::*;
#(
   parameter int OPW = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   in_a,
   input  logic [OPW-1:0]   in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*OPW-1:0] out_p,
   output logic             busy
);

   state_t             r_state;
   logic [OPW-1:0]     r_a;
   logic [OPW-1:0]     r_b;
   logic [2*OPW-1:0]   r_acc;
   logic [1:0]         r_idx;

   logic [CORE_W-1:0]   w_core_a;
   logic [CORE_W-1:0]   w_core_b;
   logic [2*CORE_W-1:0] w_core_p;
   logic [2*CORE_W-1:0] w_add_p;
   logic [1:0]          w_add_idx;
   logic [2*OPW-1:0]    w_pp_ext;
   logic                w_accept;

   // idx bit 0 selects the high half of A, bit 1 the high half of B.
   assign w_core_a = r_idx[0] ? r_a[OPW-1:CORE_W] : r_a[CORE_W-1:0];
   assign w_core_b = r_idx[1] ? r_b[OPW-1:CORE_W] : r_b[CORE_W-1:0];

   karatsuba_mul_32 u_core (
      .i_a (w_core_a),
      .i_b (w_core_b),
      .o_p (w_core_p)
   );

`ifdef KARATSUBA_MUL_64_SEQ_PIPE_EN
   logic [2*CORE_W-1:0] r_pp;
   logic [1:0]          r_pp_idx;
   logic                r_pp_vld;
   logic                r_drain;

   assign w_add_p   = r_pp;
   assign w_add_idx = r_pp_idx;
`else
   assign w_add_p   = w_core_p;
   assign w_add_idx = r_idx;
`endif

   assign w_pp_ext = {{(2*OPW-2*CORE_W){1'b0}}, w_add_p} << pp_shift(w_add_idx);

   assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == MUL);
   assign out_p     = r_acc;
   assign w_accept  = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_idx    <= '0;
`ifdef KARATSUBA_MUL_64_SEQ_PIPE_EN
         r_pp     <= '0;
         r_pp_idx <= '0;
         r_pp_vld <= 1'b0;
         r_drain  <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a      <= in_a;
         r_b      <= in_b;
         r_acc    <= '0;
         r_idx    <= '0;
         r_state  <= MUL;
`ifdef KARATSUBA_MUL_64_SEQ_PIPE_EN
         r_pp_vld <= 1'b0;
         r_drain  <= 1'b0;
`endif
      end else begin
         case (r_state)
            MUL: begin
`ifdef KARATSUBA_MUL_64_SEQ_PIPE_EN
               if (r_pp_vld) begin
                  r_acc <= r_acc + w_pp_ext;
               end
               if (!r_drain) begin
                  r_pp     <= w_core_p;
                  r_pp_idx <= r_idx;
                  r_pp_vld <= 1'b1;
                  r_idx    <= r_idx + 2'd1;
                  if (r_idx == LAST_IDX) begin
                     r_drain <= 1'b1;
                  end
               end else begin
                  r_pp_vld <= 1'b0;
                  r_drain  <= 1'b0;
                  r_state  <= DONE;
               end
`else
               r_acc <= r_acc + w_pp_ext;
               r_idx <= r_idx + 2'd1;
               if (r_idx == LAST_IDX) begin
                  r_state <= DONE;
               end
`endif
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            IDLE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/karatsuba_mul_64_seq.md
# karatsuba_mul_64_seq

Iterative 64x64 unsigned multiplier that sits directly upstream of the combinational `karatsuba_mul_32` core. It accepts 64-bit operand pairs over a valid/ready handshake and feeds the core four 32-bit half-word pairs on consecutive cycles. It accumulates the shifted partial products into a 128-bit result and presents that result on a valid/ready output port.

## Interface
- `OPW`, 64: operand width. Fixed at 2x the core width; any other value is illegal.
- `clk` input 1: the only clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an operand pair is presented.
- `in_ready` output 1: the block can accept an operand pair this cycle.
- `in_a` input OPW: multiplicand, unsigned.
- `in_b` input OPW: multiplier, unsigned.
- `out_valid` output 1: `out_p` holds a completed product.
- `out_ready` input 1: the consumer takes the product.
- `out_p` output 2*OPW: unsigned product `in_a*in_b`.
- `busy` output 1: high when the FSM is in MUL.

## Operation
- FSM states are IDLE, MUL and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid&&in_ready`: latch `in_a`/`in_b`, clear `acc` to 0, set `idx`=0, go to MUL.
- **MUL** (`idx` = 0..3, 2-bit counter)
  - The core inputs are muxed from the latched operands.
  - idx0: A0*B0, shift 0.
  - idx1: A1*B0, shift 32.
  - idx2: A0*B1, shift 32.
  - idx3: A1*B1, shift 64.
  - Each edge does `acc <= acc + (P << shift)`, with zero-extension to 128 bits. The sum cannot overflow 128 bits; no carry-out is kept.
  - Leave MUL for DONE on the edge that accumulates idx3.
- **DONE**
  - `out_valid`=1 and `out_p`=`acc`.
  - `out_p` is held stable until `out_valid&&out_ready`.
  - On that handshake: if `in_valid` is also high, accept the new pair (same actions as IDLE) and go to MUL. Otherwise go to IDLE.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is low throughout MUL.
- `in_a`/`in_b` are ignored outside accept cycles. Changing them during MUL has no effect.
- Async reset mid-operation abandons the operation. No partial result is ever presented.

## Timing
- Reset values:
  - state=IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `busy`=0
  - `out_p`=0 (acc=0)
  - idx=0
- Latency: the accept edge is E0. `out_valid` rises after E4, i.e. 4 cycles after accept.
- Throughput: one product per 5 cycles with `out_ready` held high. The DONE cycle overlaps the next accept.
- Backpressure: with `out_ready` low, the FSM stays in DONE indefinitely. `out_p` must not change and `in_ready`=0.
- `out_valid`, `in_ready` and `busy` are decoded from registered state only. None of them may depend combinationally on `in_valid`. `in_ready` may depend on `out_ready`.

## Configuration
- `KARATSUBA_MUL_64_SEQ_PIPE_EN` defined:
  - A 64-bit register is inserted between the core output and the accumulator, together with a delayed copy of `idx`.
  - MUL lasts 5 cycles: idx 0..3 issue, plus one drain cycle.
  - Latency becomes 5 cycles; throughput is one product per 6 cycles.
  - This cuts the core-plus-128-bit-adder critical path.
- Undefined: the core output feeds the adder combinationally, with the 4-cycle latency described above.
- Results must be bit-identical in both builds.

## Structure
- Shared package `karatsuba_pkg` holds:
  - the state enum (IDLE/MUL/DONE)
  - `CORE_W`=32
  - `NUM_PP`=4
  - the partial-product shift constants (0, 32, 32, 64)
- One sub-module: an instance of `karatsuba_mul_32` (existing, combinational).
- Operand muxing, the counter, the FSM and the accumulator all live in the top module.

## Test plan
- Reset then A=3, B=5 with `out_ready`=1 -> `out_valid` 4 cycles after accept, `out_p`=15. Cycle count is 5 with PIPE_EN.
- A=B=0xFFFF_FFFF_FFFF_FFFF -> `out_p`=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- A=B=0x1_0000_0000 -> `out_p`=0x1_0000_0000_0000_0000. A=0 with any B -> 0.
- Hold `out_ready`=0 for 10 cycles after `out_valid` rises:
  - `out_p` remains stable.
  - `in_ready`=0 while `in_valid`=1.
  - On release, the product is taken exactly once.
- Back-to-back: `in_valid` held high with 3 operand pairs and `out_ready`=1 -> a new accept on every DONE cycle, products in order, spacing 5 cycles.
- Assert `rst_n` low at idx2 of an operation -> all outputs take reset values immediately. After release the next op (7*9) yields 63 with no residue from the aborted op.
